// File: rtl/npu_pkg.sv
// npu_pkg -- shared types and constants for the requantisation block.
//   state_t     : job FSM encoding (IDLE, RUN, DRAIN, FIN)
//   INT8_MAX/MIN: saturation bounds of the int8 output
//   *_DEF       : default ACC_W, PACK and ADDR_W parameter values
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam int INT8_MAX   = 127;
    localparam int INT8_MIN   = -128;

    localparam int ACC_W_DEF  = 32;
    localparam int PACK_DEF   = 4;
    localparam int ADDR_W_DEF = 10;

endpackage

// File: rtl/npu_requant_sat.sv
// npu_requant_sat -- combinational requantisation of one element.
// Build option: NPU_REQUANT_RELU_EN (negative results clamp to 0).
// Ports:
//   acc, bias, shift -> r  : bias add, round-half-up, arithmetic right shift
//   r_in             -> q  : saturate to int8 (optionally ReLU first)
// The two halves are independent so one instance serves both pipe stages:
// the first half feeds stage 1, the registered r comes back in as r_in.
module npu_requant_sat
    import npu_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int IW    = 35
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [ACC_W-1:0] bias,
    input  logic        [4:0]       shift,
    output logic signed [IW-1:0]    r,
    input  logic signed [IW-1:0]    r_in,
    output logic        [7:0]       q
);

    logic signed [IW-1:0] s;
    logic signed [IW-1:0] rnd;

    // IW leaves room for the bias-add carry plus a 2^30 rounding term,
    // so nothing wraps before the shift.
    always_comb begin
        s   = IW'(acc) + IW'(bias);
        rnd = (shift == 5'd0) ? '0 : (IW'(1) << (shift - 5'd1));
        r   = (s + rnd) >>> shift;
    end

    always_comb begin
        q = r_in[7:0];
`ifdef NPU_REQUANT_RELU_EN
        if (r_in < 0)
            q = 8'd0;
        else if (r_in > IW'(INT8_MAX))
            q = 8'(INT8_MAX);
`else
        if (r_in > IW'(INT8_MAX))
            q = 8'(INT8_MAX);
        else if (r_in < IW'(INT8_MIN))
            q = 8'(INT8_MIN);
`endif
    end

endmodule

// File: rtl/npu_requant.sv
// npu_requant -- accumulator requantiser: (acc + bias) rounded, shifted,
// saturated to int8 and packed PACK per word into an output buffer.
// Build option: NPU_REQUANT_RELU_EN (ReLU before saturation).
// Ports:
//   CLOCK_100, reset_n        : clock, async active-low reset
//   start, base_addr,
//   len_words, bias, shift    : job launch and configuration (latched in IDLE)
//   acc_valid/acc_data/acc_ready : element stream in
//   wr_en/wr_addr/wr_data     : packed word writes out
//   busy, done                : job status
// Pipe: handshake -> stage 1 (r) -> stage 2 (lane fill / word write).
module npu_requant
    import npu_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PACK   = PACK_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    CLOCK_100,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W:0]         len_words,
    input  logic signed [ACC_W-1:0] bias,
    input  logic [4:0]              shift,
    input  logic                    acc_valid,
    input  logic signed [ACC_W-1:0] acc_data,
    output logic                    acc_ready,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*PACK-1:0]       wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam int IW    = ((ACC_W > 31) ? ACC_W : 31) + 3;
    localparam int LW    = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CNT_W = ADDR_W + 1 + LW;

    state_t                   state, state_nx;
    logic [ADDR_W:0]          len_q;
    logic signed [ACC_W-1:0]  bias_q;
    logic [4:0]               shift_q;
    logic [CNT_W-1:0]         elem_cnt;
    logic [LW-1:0]            lane_idx;
    logic [PACK-1:0][7:0]     lane_buf;
    logic [PACK-1:0][7:0]     merged;
    logic signed [IW-1:0]     r_w, r_q;
    logic [7:0]               q_w;
    // [0]: stage-1 element valid, [1]: stage-2 word write
    logic [1:0]               vld_pipe;
    logic                     hs, last_elem, launch, lane_last;

    assign hs        = acc_valid & acc_ready;
    assign launch    = (state == IDLE) & start;
    assign last_elem = elem_cnt == (CNT_W'(len_q) * CNT_W'(PACK)) - CNT_W'(1);
    assign lane_last = lane_idx == LW'(PACK - 1);
    assign wr_en     = vld_pipe[1];

    npu_requant_sat #(.ACC_W(ACC_W), .IW(IW)) u_sat (
        .acc   (acc_data),
        .bias  (bias_q),
        .shift (shift_q),
        .r     (r_w),
        .r_in  (r_q),
        .q     (q_w)
    );

    always_comb begin
        state_nx  = state;
        acc_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nx = (len_words == '0) ? FIN : RUN;
            end
            RUN: begin
                acc_ready = 1'b1;
                if (hs && last_elem)
                    state_nx = DRAIN;
            end
            // Last word is out once a write happens with nothing left in stage 1.
            DRAIN: if (wr_en && !vld_pipe[0]) state_nx = FIN;
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_100 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            len_q    <= '0;
            bias_q   <= '0;
            shift_q  <= '0;
            elem_cnt <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                len_q    <= len_words;
                bias_q   <= bias;
                shift_q  <= shift;
                elem_cnt <= '0;
            end else if (hs) begin
                elem_cnt <= elem_cnt + CNT_W'(1);
            end
        end
    end

    // The final lane goes straight into the write word rather than lane_buf.
    always_comb begin
        merged           = lane_buf;
        merged[PACK-1]   = q_w;
    end

    always_ff @(posedge CLOCK_100 or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            r_q      <= '0;
            lane_idx <= '0;
            lane_buf <= '0;
            wr_data  <= '0;
            wr_addr  <= '0;
        end else begin
            vld_pipe[0] <= hs;
            vld_pipe[1] <= vld_pipe[0] & lane_last;
            if (hs)
                r_q <= r_w;
            if (vld_pipe[0]) begin
                if (lane_last) begin
                    lane_idx <= '0;
                    wr_data  <= merged;
                end else begin
                    lane_buf[lane_idx] <= q_w;
                    lane_idx           <= lane_idx + LW'(1);
                end
            end
            // wr_addr always holds the address of the next write.
            if (launch)
                wr_addr <= base_addr;
            else if (wr_en)
                wr_addr <= wr_addr + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_npu_requant.sv
module tb_npu_requant;
    import npu_pkg::*;

    localparam int ACC_W  = 32;
    localparam int PACK   = 4;
    localparam int ADDR_W = 10;

`ifdef NPU_REQUANT_RELU_EN
    localparam logic [31:0] S2_DATA = 32'h0102007F;
    localparam logic [31:0] S3_DATA = 32'h007F007F;
`else
    localparam logic [31:0] S2_DATA = 32'h0102807F;
    localparam logic [31:0] S3_DATA = 32'hFE7F807F;
`endif

    logic                    CLOCK_100 = 1'b0;
    logic                    reset_n   = 1'b0;
    logic                    start     = 1'b0;
    logic [ADDR_W-1:0]       base_addr = '0;
    logic [ADDR_W:0]         len_words = '0;
    logic signed [ACC_W-1:0] bias      = '0;
    logic [4:0]              shift     = '0;
    logic                    acc_valid = 1'b0;
    logic signed [ACC_W-1:0] acc_data  = '0;
    logic                    acc_ready, wr_en, busy, done;
    logic [ADDR_W-1:0]       wr_addr;
    logic [8*PACK-1:0]       wr_data;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [8*PACK-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  lat_q[$];
    wr_t mon_e;
    int  cyc = 0, n_checks = 0, n_fail = 0, hs_cnt = 0, last_wr_cyc = -1;

    npu_requant #(.ACC_W(ACC_W), .PACK(PACK), .ADDR_W(ADDR_W)) dut (
        .CLOCK_100 (CLOCK_100),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .len_words (len_words),
        .bias      (bias),
        .shift     (shift),
        .acc_valid (acc_valid),
        .acc_data  (acc_data),
        .acc_ready (acc_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLOCK_100 = ~CLOCK_100;
    always @(posedge CLOCK_100) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected words and write latencies whenever a write appears.
    always @(negedge CLOCK_100) begin
        if (!reset_n) begin
            hs_cnt = 0;
            lat_q.delete();
        end else begin
            if (wr_en) begin
                last_wr_cyc = cyc;
                chk("write_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                    chk("wr_data", 64'(wr_data), 64'(mon_e.data));
                end
                chk("latency_tracked", 64'(lat_q.size() > 0), 1);
                if (lat_q.size() > 0)
                    chk("wr_latency", 64'(cyc), 64'(lat_q.pop_front()));
            end
            if (acc_valid && acc_ready) begin
                hs_cnt++;
                if (hs_cnt % PACK == 0)
                    lat_q.push_back(cyc + 2);
            end
        end
    end

    task automatic push_exp(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr[ADDR_W-1:0];
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int base, input int len, input int b, input int sh,
                            output int s_cyc);
        base_addr = base[ADDR_W-1:0];
        len_words = len[ADDR_W:0];
        bias      = b;
        shift     = sh[4:0];
        start     = 1'b1;
        @(negedge CLOCK_100);
        s_cyc = cyc;
        @(posedge CLOCK_100);
        #1 start = 1'b0;
    endtask

    task automatic send(input int d, input int gap);
        int n = 0;
        acc_valid = 1'b1;
        acc_data  = d;
        @(negedge CLOCK_100);
        while (!acc_ready && n < 50) begin
            @(negedge CLOCK_100);
            n++;
        end
        if (!acc_ready) chk("acc_ready_timeout", 64'(acc_ready), 1);
        @(posedge CLOCK_100);
        #1 acc_valid = 1'b0;
        repeat (gap) begin
            @(posedge CLOCK_100);
            #1;
        end
    endtask

    task automatic wait_done(input int exp_cyc, input bit after_wr, input bit restart);
        int n = 0;
        @(negedge CLOCK_100);
        while (!done && n < 200) begin
            @(negedge CLOCK_100);
            n++;
        end
        chk("done_seen", 64'(done), 1);
        if (done) begin
            chk("done_cycle", 64'(cyc), after_wr ? 64'(last_wr_cyc + 1) : 64'(exp_cyc));
            chk("busy_at_done", 64'(busy), 1);
            if (restart) begin
                start     = 1'b1;
                len_words = 1;
                base_addr = 7;
            end
            @(posedge CLOCK_100);
            #1 start = 1'b0;
            @(negedge CLOCK_100);
            chk("idle_after_done", 64'({busy, done, acc_ready}), 0);
        end
        @(posedge CLOCK_100);
        #1;
    endtask

    initial begin
        int sc;
        repeat (3) @(posedge CLOCK_100);
        #1;
        chk("rst_ctrl", 64'({acc_ready, wr_en, busy, done}), 0);
        chk("rst_wr_addr", 64'(wr_addr), 0);
        chk("rst_wr_data", 64'(wr_data), 0);
        reset_n = 1'b1;
        @(posedge CLOCK_100);
        #1;

        // Basic packing
        push_exp(5, 32'h04030201);
        do_start(5, 1, 0, 0, sc);
        chk("busy_after_start", 64'(busy), 1);
        for (int i = 1; i <= 4; i++) send(i, 0);
        wait_done(0, 1'b1, 1'b0);

        // Saturation and round-half-up
        push_exp(10, S2_DATA);
        do_start(10, 1, 0, 2, sc);
        send(1000, 0); send(-1000, 0); send(6, 0); send(5, 0);
        wait_done(0, 1'b1, 1'b0);

        // Bias overflow must not wrap
        push_exp(11, S3_DATA);
        do_start(11, 1, 1, 0, sc);
        send(32'h7FFFFFFF, 0); send(-130, 0); send(126, 0); send(-3, 0);
        wait_done(0, 1'b1, 1'b0);

        // Extreme bias with shift 31
        push_exp(12, 32'h01010002);
        do_start(12, 1, 32'h7FFFFFFF, 31, sc);
        send(32'h7FFFFFFF, 0); send(32'h80000000, 0); send(32'h40000000, 0); send(0, 0);
        wait_done(0, 1'b1, 1'b0);

        // Address wrap with bubbles
        push_exp(1023, 32'h04030201);
        push_exp(0,    32'h08070605);
        do_start(1023, 2, 0, 0, sc);
        for (int i = 1; i <= 8; i++) send(i, 1);
        wait_done(0, 1'b1, 1'b0);

        // Empty job; start coincident with done is ignored
        do_start(3, 0, 0, 0, sc);
        wait_done(sc + 1, 1'b0, 1'b1);

        // Start while busy is ignored
        push_exp(20, 32'h0D0C0B0A);
        do_start(20, 1, 0, 0, sc);
        start     = 1'b1;
        base_addr = 30;
        len_words = 0;
        @(posedge CLOCK_100);
        #1 start = 1'b0;
        chk("busy_ignored_start", 64'(busy), 1);
        for (int i = 10; i <= 13; i++) send(i, 0);
        wait_done(0, 1'b1, 1'b0);

        // Reset mid-job
        do_start(40, 1, 0, 0, sc);
        send(1, 0);
        send(2, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({acc_ready, wr_en, busy, done}), 0);
        chk("midrst_wr_addr", 64'(wr_addr), 0);
        chk("midrst_wr_data", 64'(wr_data), 0);
        repeat (2) @(posedge CLOCK_100);
        #1 reset_n = 1'b1;
        @(posedge CLOCK_100);
        #1;
        push_exp(50, 32'h0C0B0A09);
        do_start(50, 1, 0, 0, sc);
        for (int i = 9; i <= 12; i++) send(i, 0);
        wait_done(0, 1'b1, 1'b0);

        repeat (3) @(posedge CLOCK_100);
        chk("all_writes_seen", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
